assembler_line_sequencer: RTL
=============================

// Module: assembler_line_sequencer
// PURPOSE
//  Feeds a byte stream of assembly source, one line at a time, into the per-line instruction parser.
//  Collects each parsed 32-bit word and writes it to instruction memory at sequential addresses.
//  Sits between the source character buffer (UART/BRAM reader) and the instruction_by_line parser.
//  Reports done, or the first error with its code and 1-based source line number.
// PARAMETERS
//  CHAR_PER_LINE  64    max printable chars per line; reaching it without '\n' is an error
//  IMEM_DEPTH     1024  instruction memory words; ADDR_W = $clog2(IMEM_DEPTH)
//  PARSE_TIMEOUT  16    cycles allowed in WAIT_PARSE before a timeout error
// PORTS
//  clk_in           in   1       single clock; all logic on posedge
//  rst_in           in   1       synchronous, active-low reset (0 = reset)
//  start_in         in   1       pulse; begins assembly from IDLE, DONE or ERROR
//  char_valid_in    in   1       source byte valid
//  char_in          in   8       source byte (ASCII)
//  char_ready_out   out  1       byte accepted on a cycle where valid && ready
//  parser_line_out  out  1       1-cycle pulse: start new line (parser new_line)
//  parser_char_vld  out  1       1-cycle pulse: parser_char valid (parser new_character)
//  parser_char      out  8       byte forwarded to parser
//  parser_eol_out   out  1       1-cycle pulse: line complete, parser must finish
//  parser_inst_in   in   32      parsed instruction
//  parser_ready_in  in   1       instruction valid
//  parser_error_in  in   1       parser rejected the line
//  imem_we_out      out  1       instruction memory write strobe
//  imem_addr_out    out  ADDR_W  write address
//  imem_data_out    out  32      write data
//  busy_out         out  1       high in any state except IDLE/DONE/ERROR
//  done_out         out  1       high while in DONE
//  error_out        out  1       high while in ERROR
//  error_code_out   out  3       0 none,1 parse,2 timeout,3 line too long,4 imem full
//  error_line_out   out  16      1-based line number of the fault
//  inst_count_out   out  ADDR_W+1 instructions written
// BEHAVIOUR
//  Reset (rst_in==0): state IDLE; every output 0; address, line and char counters cleared.
//  FSM: IDLE, NEW_LINE, FEED, SKIP, WAIT_PARSE, WRITE, DONE, ERROR.
//  IDLE/DONE/ERROR + start_in: clear counters and error fields, line=1 -> NEW_LINE.
//  NEW_LINE: parser_line_out=1 for one cycle, char count=0 -> FEED.
//  FEED: char_ready_out=1; per accepted byte:
//   '\n'(0x0A): count==0 -> line++, NEW_LINE (no write); else parser_eol_out pulse -> WAIT_PARSE.
//   0x00 (EOF): count==0 -> DONE; else set eof flag, parser_eol_out pulse -> WAIT_PARSE.
//   ';': count==0 -> SKIP; else parser_eol_out pulse -> SKIP then WAIT_PARSE on '\n'/EOF.
//   '\r': dropped, no count change.
//   other: parser_char=byte, parser_char_vld pulse next cycle, count++.
//   If count reaches CHAR_PER_LINE -> ERROR code 3.
//  SKIP: char_ready_out=1; discard bytes until '\n' or 0x00, then act as that byte in FEED.
//   Content before ';' is already sent and the eol already pulsed.
//  WAIT_PARSE: char_ready_out=0; wait counter from 0.
//   parser_error_in -> ERROR code 1; wins over a simultaneous ready.
//   else parser_ready_in -> latch parser_inst_in -> WRITE.
//   counter==PARSE_TIMEOUT-1 with neither -> ERROR code 2.
//  WRITE: imem_we_out=1 one cycle with current addr/data; addr++, inst_count++.
//   Next: eof ? DONE : (line++, NEW_LINE).
//   If the write used address IMEM_DEPTH-1 and more lines follow, the next write attempt gives ERROR code 4.
//   No wrap-around, no overwrite of word 0.
//  error_line_out = line counter at error entry. Line counter saturates at 0xFFFF.
//  ERROR/DONE: hold all status; char_ready_out=0, no writes, until start_in or reset.
//  start_in is ignored while busy_out=1. Reset mid-line aborts immediately; memory is not cleaned.
//  Latency: last line byte -> eol pulse 1 cycle; parser ready -> imem write 1 cycle.
// TESTING
//  1 "addi x1,x0,5\n" + 0x00, parser ready after 3 cycles w/ 0x00500093 -> one write addr0 data 0x00500093, done, count=1.
//  2 "\n\n;c\nnop\n" + 0x00 -> single write at addr0; blank and comment lines cause no parser eol.
//  3 line 3 with parser_error_in -> error_out=1, code 1, line 3, no write for that line.
//  4 parser silent 16 cycles -> code 2; 64 printable chars without '\n' -> code 3.
//  5 IMEM_DEPTH=4, 5 lines -> writes addr0..3 then code 4, line 5.
//  6 rst_in=0 mid-FEED -> next cycle all outputs 0, IDLE; start_in restarts at addr0, line 1.

Source files
------------

// File: rtl/assembler_line_sequencer.sv
// assembler_line_sequencer: streams source bytes line by line into the instruction parser
// and writes each parsed word to instruction memory at sequential addresses.
module assembler_line_sequencer #(
    parameter int CHAR_PER_LINE = 64,
    parameter int IMEM_DEPTH    = 1024,
    parameter int PARSE_TIMEOUT = 16,
    parameter int ADDR_W        = $clog2(IMEM_DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              char_valid_in,
    input  logic [7:0]        char_in,
    output logic              char_ready_out,
    output logic              parser_line_out,
    output logic              parser_char_vld,
    output logic [7:0]        parser_char,
    output logic              parser_eol_out,
    input  logic [31:0]       parser_inst_in,
    input  logic              parser_ready_in,
    input  logic              parser_error_in,
    output logic              imem_we_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    output logic [31:0]       imem_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic [2:0]        error_code_out,
    output logic [15:0]       error_line_out,
    output logic [ADDR_W:0]   inst_count_out
);
    localparam int CW = $clog2(CHAR_PER_LINE + 1);
    localparam int WW = $clog2(PARSE_TIMEOUT);
    typedef enum logic [2:0] {IDLE, NEW_LINE, FEED, SKIP, WAIT_PARSE, WRITE, DONE, ERROR} state_t;
    state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [15:0]     line_q, line_d, eline_q, eline_d, line_inc;
    logic [ADDR_W:0] icnt_q, icnt_d;
    logic [31:0]     data_q, data_d;
    logic [7:0]      pchar_q, pchar_d;
    logic [2:0]      ecode_q, ecode_d, err_code;
    logic            eof_q, eof_d, pvld_q, pvld_d, peol_q, peol_d;
    logic            is_eof, is_end, full;
    assign is_eof   = char_in == 8'h00;
    assign is_end   = is_eof || char_in == 8'h0A;
    assign line_inc = (line_q == 16'hFFFF) ? line_q : line_q + 16'd1;
    assign full     = icnt_q == (ADDR_W+1)'(IMEM_DEPTH);
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            line_q  <= '0;
            eline_q <= '0;
            icnt_q  <= '0;
            data_q  <= '0;
            pchar_q <= '0;
            ecode_q <= '0;
            eof_q   <= 1'b0;
            pvld_q  <= 1'b0;
            peol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            line_q  <= line_d;
            eline_q <= eline_d;
            icnt_q  <= icnt_d;
            data_q  <= data_d;
            pchar_q <= pchar_d;
            ecode_q <= ecode_d;
            eof_q   <= eof_d;
            pvld_q  <= pvld_d;
            peol_q  <= peol_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        line_d   = line_q;
        eline_d  = eline_q;
        icnt_d   = icnt_q;
        data_d   = data_q;
        pchar_d  = pchar_q;
        ecode_d  = ecode_q;
        eof_d    = eof_q;
        pvld_d   = 1'b0;
        peol_d   = 1'b0;
        err_code = 3'd0;
        case (state_q)
            IDLE, DONE, ERROR: if (start_in) begin
                state_d = NEW_LINE;
                cnt_d   = '0;
                icnt_d  = '0;
                line_d  = 16'd1;
                eof_d   = 1'b0;
                ecode_d = 3'd0;
                eline_d = 16'd0;
            end
            NEW_LINE: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED, SKIP: if (char_valid_in) begin
                // A non-empty line skipped after ';' already had its eol pulsed, so no second one.
                if (is_end) begin
                    if (cnt_q == '0) begin
                        state_d = is_eof ? DONE : NEW_LINE;
                        line_d  = is_eof ? line_q : line_inc;
                    end else begin
                        state_d = WAIT_PARSE;
                        wcnt_d  = '0;
                        eof_d   = is_eof;
                        peol_d  = state_q == FEED;
                    end
                end else if (state_q == FEED && char_in == 8'h3B) begin
                    state_d = SKIP;
                    peol_d  = cnt_q != '0;
                end else if (state_q == FEED && char_in != 8'h0D) begin
                    pchar_d = char_in;
                    pvld_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(CHAR_PER_LINE - 1)) err_code = 3'd3;
                end
            end
            WAIT_PARSE: begin
                wcnt_d = wcnt_q + 1'b1;
                if (parser_error_in) err_code = 3'd1;
                else if (parser_ready_in) begin
                    if (full) err_code = 3'd4;
                    else begin
                        data_d  = parser_inst_in;
                        state_d = WRITE;
                    end
                end else if (wcnt_q == WW'(PARSE_TIMEOUT - 1)) err_code = 3'd2;
            end
            WRITE: begin
                icnt_d  = icnt_q + 1'b1;
                state_d = eof_q ? DONE : NEW_LINE;
                line_d  = eof_q ? line_q : line_inc;
            end
            default: ;
        endcase
        if (err_code != 3'd0) begin
            state_d = ERROR;
            ecode_d = err_code;
            eline_d = line_q;
        end
    end
    always_comb begin
        char_ready_out  = state_q == FEED || state_q == SKIP;
        parser_line_out = state_q == NEW_LINE;
        imem_we_out     = state_q == WRITE;
        done_out        = state_q == DONE;
        error_out       = state_q == ERROR;
        busy_out        = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
        parser_char_vld = pvld_q;
        parser_char     = pchar_q;
        parser_eol_out  = peol_q;
        imem_addr_out   = icnt_q[ADDR_W-1:0];
        imem_data_out   = data_q;
        error_code_out  = ecode_q;
        error_line_out  = eline_q;
        inst_count_out  = icnt_q;
    end
endmodule
